// File: rtl/apb_master.sv
// APB3 requester: turns a valid/ready command into SETUP/ACCESS transfers.
// Optional ACCESS timeout abort is built when APB_TIMEOUT_EN is defined.
module apb_master #(
  parameter int ADDRESSWIDTH   = 3,
  parameter int DATAWIDTH      = 12,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    PCLK,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDRESSWIDTH-1:0] cmd_addr,
  input  logic [DATAWIDTH-1:0]    cmd_wdata,
  output logic                    resp_valid,
  output logic [DATAWIDTH-1:0]    resp_rdata,
  output logic                    resp_err,
  output logic [ADDRESSWIDTH-1:0] PADDR,
  output logic [DATAWIDTH-1:0]    PWDATA,
  output logic                    PWRITE,
  output logic                    PSELx,
  output logic                    PENABLE,
  input  logic [DATAWIDTH-1:0]    PRDATA,
  input  logic                    PREADY
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  state_t                  state_q;
  state_t                  state_d;
  logic                    ready_d;
  logic                    valid_d;
  logic [DATAWIDTH-1:0]    rdata_d;
  logic [ADDRESSWIDTH-1:0] addr_d;
  logic [DATAWIDTH-1:0]    wdata_d;
  logic                    write_d;
  logic                    sel_d;
  logic                    en_d;

`ifdef APB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          err_q;
  logic          err_d;

  assign resp_err = err_q;
`else
  assign resp_err = 1'b0;
`endif

  // Next-state and next-output logic; every output is a register
  always_comb begin
    state_d = state_q;
    ready_d = cmd_ready;
    valid_d = 1'b0;
    rdata_d = resp_rdata;
    addr_d  = PADDR;
    wdata_d = PWDATA;
    write_d = PWRITE;
    sel_d   = PSELx;
    en_d    = PENABLE;
`ifdef APB_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        sel_d   = 1'b0;
        en_d    = 1'b0;
        if (cmd_valid && cmd_ready) begin
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          write_d = cmd_write;
          sel_d   = 1'b1;
          ready_d = 1'b0;
          state_d = SETUP;
`ifdef APB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      SETUP: begin
        en_d    = 1'b1;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (PREADY) begin
          sel_d   = 1'b0;
          en_d    = 1'b0;
          valid_d = 1'b1;
          rdata_d = PWRITE ? '0 : PRDATA;
          ready_d = 1'b1;
          state_d = IDLE;
`ifdef APB_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
`ifdef APB_TIMEOUT_EN
        else if (cnt_q == LAST) begin
          sel_d   = 1'b0;
          en_d    = 1'b0;
          valid_d = 1'b1;
          rdata_d = '0;
          err_d   = 1'b1;
          ready_d = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge PCLK or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cmd_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      PADDR      <= '0;
      PWDATA     <= '0;
      PWRITE     <= 1'b0;
      PSELx      <= 1'b0;
      PENABLE    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_ready  <= ready_d;
      resp_valid <= valid_d;
      resp_rdata <= rdata_d;
      PADDR      <= addr_d;
      PWDATA     <= wdata_d;
      PWRITE     <= write_d;
      PSELx      <= sel_d;
      PENABLE    <= en_d;
    end
  end

`ifdef APB_TIMEOUT_EN
  // Wait counter and sticky error flag for the timeout abort
  always_ff @(posedge PCLK or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
`endif

endmodule

// File: tb/tb_apb_master.sv
// Directed self-checking bench for apb_master.
// Timeout scenario runs only when APB_TIMEOUT_EN is defined.
module tb_apb_master;

  logic        PCLK;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [2:0]  cmd_addr;
  logic [11:0] cmd_wdata;
  logic        resp_valid;
  logic [11:0] resp_rdata;
  logic        resp_err;
  logic [2:0]  PADDR;
  logic [11:0] PWDATA;
  logic        PWRITE;
  logic        PSELx;
  logic        PENABLE;
  logic [11:0] PRDATA;
  logic        PREADY;

  int checks = 0;
  int errors = 0;

  apb_master #(
    .ADDRESSWIDTH  (3),
    .DATAWIDTH     (12),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .PCLK      (PCLK),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PWRITE    (PWRITE),
    .PSELx     (PSELx),
    .PENABLE   (PENABLE),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    PRDATA    = '0;
    PREADY    = 1'b0;

    // 1. reset state and idle PREADY toggle
    step();
    step();
    chk("rst_ready", 32'(cmd_ready), 0);
    chk("rst_sel", 32'(PSELx), 0);
    chk("rst_en", 32'(PENABLE), 0);
    chk("rst_valid", 32'(resp_valid), 0);
    chk("rst_rdata", 32'(resp_rdata), 0);
    chk("rst_err", 32'(resp_err), 0);
    chk("rst_addr", 32'(PADDR), 0);
    chk("rst_wdata", 32'(PWDATA), 0);
    chk("rst_write", 32'(PWRITE), 0);
    reset = 1'b0;
    step();
    chk("idle_ready", 32'(cmd_ready), 1);
    PREADY = 1'b1;
    step();
    PREADY = 1'b0;
    step();
    chk("idle_sel", 32'(PSELx), 0);
    chk("idle_en", 32'(PENABLE), 0);
    chk("idle_valid", 32'(resp_valid), 0);

    // 2. write, zero wait states
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 3'd2;
    cmd_wdata = 12'hA5C;
    PREADY    = 1'b1;
    step();
    cmd_valid = 1'b0;
    cmd_addr  = 3'd7;
    cmd_wdata = 12'hFFF;
    cmd_write = 1'b0;
    chk("w_setup_sel", 32'(PSELx), 1);
    chk("w_setup_en", 32'(PENABLE), 0);
    chk("w_setup_ready", 32'(cmd_ready), 0);
    chk("w_addr", 32'(PADDR), 2);
    chk("w_wdata", 32'(PWDATA), 12'hA5C);
    chk("w_write", 32'(PWRITE), 1);
    step();
    chk("w_acc_sel", 32'(PSELx), 1);
    chk("w_acc_en", 32'(PENABLE), 1);
    chk("w_acc_addr", 32'(PADDR), 2);
    chk("w_acc_valid", 32'(resp_valid), 0);
    step();
    chk("w_done_valid", 32'(resp_valid), 1);
    chk("w_done_err", 32'(resp_err), 0);
    chk("w_done_rdata", 32'(resp_rdata), 0);
    chk("w_done_sel", 32'(PSELx), 0);
    chk("w_done_en", 32'(PENABLE), 0);
    chk("w_done_ready", 32'(cmd_ready), 1);
    step();
    chk("w_pulse", 32'(resp_valid), 0);
    chk("w_hold_addr", 32'(PADDR), 2);
    chk("w_hold_write", 32'(PWRITE), 1);

    // 3. read with four wait states
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 3'd1;
    PREADY    = 1'b0;
    PRDATA    = 12'h3F0;
    step();
    cmd_valid = 1'b0;
    cmd_addr  = 3'd6;
    chk("r_setup_write", 32'(PWRITE), 0);
    step();
    for (int i = 0; i < 5; i++) begin
      chk("r_acc_en", 32'(PENABLE), 1);
      chk("r_acc_addr", 32'(PADDR), 1);
      chk("r_acc_valid", 32'(resp_valid), 0);
      if (i == 4) PREADY = 1'b1;
      step();
    end
    chk("r_done_valid", 32'(resp_valid), 1);
    chk("r_done_rdata", 32'(resp_rdata), 12'h3F0);
    chk("r_done_err", 32'(resp_err), 0);
    PRDATA = 12'h000;
    step();
    chk("r_pulse", 32'(resp_valid), 0);
    chk("r_hold_rdata", 32'(resp_rdata), 12'h3F0);

    // 4. back-to-back with cmd_valid held
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 3'd5;
    cmd_wdata = 12'h111;
    PREADY    = 1'b1;
    step();
    chk("b1_wdata", 32'(PWDATA), 12'h111);
    chk("b1_ready", 32'(cmd_ready), 0);
    cmd_addr  = 3'd6;
    cmd_wdata = 12'h222;
    step();
    chk("b1_acc_addr", 32'(PADDR), 5);
    step();
    chk("b1_valid", 32'(resp_valid), 1);
    chk("b1_gap_sel", 32'(PSELx), 0);
    step();
    chk("b2_sel", 32'(PSELx), 1);
    chk("b2_addr", 32'(PADDR), 6);
    chk("b2_wdata", 32'(PWDATA), 12'h222);
    chk("b2_valid", 32'(resp_valid), 0);
    cmd_valid = 1'b0;
    step();
    step();
    chk("b2_done", 32'(resp_valid), 1);
    step();

`ifdef APB_TIMEOUT_EN
    // 5a. PREADY stuck low: abort on 16th ACCESS cycle
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 3'd3;
    PREADY    = 1'b0;
    PRDATA    = 12'h5A5;
    step();
    cmd_valid = 1'b0;
    step();
    for (int i = 0; i < 16; i++) begin
      chk("to_wait_sel", 32'(PSELx), 1);
      chk("to_wait_valid", 32'(resp_valid), 0);
      step();
    end
    chk("to_valid", 32'(resp_valid), 1);
    chk("to_err", 32'(resp_err), 1);
    chk("to_rdata", 32'(resp_rdata), 0);
    chk("to_sel", 32'(PSELx), 0);
    chk("to_en", 32'(PENABLE), 0);
    step();
    chk("to_pulse", 32'(resp_valid), 0);
    chk("to_err_hold", 32'(resp_err), 1);

    // 5b. PREADY rises on the 16th cycle: completion wins
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    step();
    for (int i = 0; i < 16; i++) begin
      chk("tw_wait_valid", 32'(resp_valid), 0);
      if (i == 15) PREADY = 1'b1;
      step();
    end
    chk("tw_valid", 32'(resp_valid), 1);
    chk("tw_err", 32'(resp_err), 0);
    chk("tw_rdata", 32'(resp_rdata), 12'h5A5);
    step();
`else
    // 5. no timeout: long wait completes without error
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 3'd3;
    PREADY    = 1'b0;
    PRDATA    = 12'h5A5;
    step();
    cmd_valid = 1'b0;
    step();
    for (int i = 0; i < 21; i++) begin
      chk("nt_wait_sel", 32'(PSELx), 1);
      chk("nt_wait_valid", 32'(resp_valid), 0);
      if (i == 20) PREADY = 1'b1;
      step();
    end
    chk("nt_valid", 32'(resp_valid), 1);
    chk("nt_err", 32'(resp_err), 0);
    chk("nt_rdata", 32'(resp_rdata), 12'h5A5);
    step();
`endif

    // 6. reset during ACCESS wait
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 3'd4;
    PREADY    = 1'b0;
    step();
    cmd_valid = 1'b0;
    step();
    step();
    chk("pre_rst_en", 32'(PENABLE), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_sel", 32'(PSELx), 0);
    chk("arst_en", 32'(PENABLE), 0);
    chk("arst_valid", 32'(resp_valid), 0);
    PREADY = 1'b1;
    step();
    reset = 1'b0;
    step();
    chk("post_valid", 32'(resp_valid), 0);
    chk("post_ready", 32'(cmd_ready), 1);
    chk("post_sel", 32'(PSELx), 0);
    cmd_valid = 1'b1;
    cmd_addr  = 3'd1;
    PRDATA    = 12'h7E1;
    step();
    cmd_valid = 1'b0;
    chk("post_addr", 32'(PADDR), 1);
    step();
    step();
    chk("post_done", 32'(resp_valid), 1);
    chk("post_rdata", 32'(resp_rdata), 12'h7E1);
    chk("post_err", 32'(resp_err), 0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
